// File: rtl/ycbcr_stream_conv_if.sv
// ---------------------------------------------------------------------------
// ycbcr_stream_conv_if
//
// AXI4-Stream video bundle used on both sides of ycbcr_stream_conv. One
// beat carries a packed three-component pixel.
//
// Parameters:
//   W       bits per colour component (tdata is 3*W wide)
//
// Signals:
//   tdata   pixel, three packed components
//   tvalid  beat valid (master -> slave)
//   tready  slave can accept the beat (slave -> master)
//   tlast   end of line
//   tuser   start of frame
//
// Modports:
//   master  drives tdata/tvalid/tlast/tuser, samples tready
//   slave   samples tdata/tvalid/tlast/tuser, drives tready
// ---------------------------------------------------------------------------
interface ycbcr_stream_conv_if #(
    parameter int W = 8
) ();

    logic [3*W-1:0] tdata;
    logic           tvalid;
    logic           tready;
    logic           tlast;
    logic           tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/ycbcr_stream_conv.sv
// ---------------------------------------------------------------------------
// ycbcr_stream_conv
//
// RGB to YCbCr 4:4:4 converter sitting on an AXI4-Stream video path. Every
// accepted beat runs through a 3-stage pipeline that stalls as a whole when
// the output register is full and downstream is not ready:
//   stage 1  source select (stream pixel or constant colour), mode, tlast, tuser
//   stage 2  the nine signed coefficient x component products
//   stage 3  sum, round, chroma offset, clamp, output format select
//
// The mode is captured together with its beat, so a mode change mid-line
// only affects beats accepted after the change.
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   mode          0 = YCbCr, 1 = RGB passthrough, 2 = constant colour, 3 = grey
//   sel_rgb       constant colour for mode 2, packed {R,B,G}
//   s_axis_video  slave stream, tdata packed {R,B,G} (R in the MSBs)
//   m_axis_video  master stream, tdata packed {Cr,Cb,Y} ({R,B,G} in mode 1)
//   frame_cnt     number of output handshakes with tuser set, wraps at 16 bits
//
// Parameters:
//   IN_W / OUT_W  input / output component width, OUT_W <= IN_W
//   COEF_W, FRAC  signed coefficient width and its fractional bits
//   K_*           conversion matrix coefficients
// ---------------------------------------------------------------------------
module ycbcr_stream_conv #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 8,
    parameter int COEF_W = 9,
    parameter int FRAC   = 8,
    parameter int K_YR   = 77,
    parameter int K_YG   = 150,
    parameter int K_YB   = 29,
    parameter int K_CBR  = -43,
    parameter int K_CBG  = -85,
    parameter int K_CBB  = 128,
    parameter int K_CRR  = 128,
    parameter int K_CRG  = -107,
    parameter int K_CRB  = -21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic [3*IN_W-1:0]     sel_rgb,
    ycbcr_stream_conv_if.slave    s_axis_video,
    ycbcr_stream_conv_if.master   m_axis_video,
    output logic [15:0]           frame_cnt
);

    typedef enum logic [1:0] {
        MODE_YCBCR = 2'd0,
        MODE_PASS  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_GREY  = 2'd3
    } mode_t;

    // Product width: unsigned component widened by one sign bit times a
    // signed coefficient. Two extra bits on the sum absorb the three-term
    // addition plus the rounding constant, so nothing wraps before the clamp.
    localparam int PW = IN_W + COEF_W + 1;
    localparam int SW = PW + 2;

    localparam logic signed [SW-1:0] ROUND      = SW'(2 ** (FRAC - 1));
    localparam logic signed [SW-1:0] CHROMA_OFS = SW'(2 ** (IN_W - 1));
    localparam logic signed [SW-1:0] COMP_MAX   = SW'((2 ** IN_W) - 1);
    localparam logic [OUT_W-1:0]     GREY_MID   = OUT_W'(2 ** (OUT_W - 1));

    // Coefficient order: channel-major (Y, Cb, Cr), component-minor (R, G, B).
    localparam logic signed [COEF_W-1:0] COEF [9] = '{
        COEF_W'(K_YR),  COEF_W'(K_YG),  COEF_W'(K_YB),
        COEF_W'(K_CBR), COEF_W'(K_CBG), COEF_W'(K_CBB),
        COEF_W'(K_CRR), COEF_W'(K_CRG), COEF_W'(K_CRB)
    };

    function automatic logic signed [PW-1:0] mul(
        input logic        [IN_W-1:0]   c,
        input logic signed [COEF_W-1:0] k
    );
        logic signed [PW-1:0] a;
        logic signed [PW-1:0] b;
        a = signed'(PW'(c));
        b = PW'(k);
        return a * b;
    endfunction

    // Clamp to the input component range, then keep the top OUT_W bits.
    function automatic logic [OUT_W-1:0] clamp_top(input logic signed [SW-1:0] v);
        logic [IN_W-1:0] c;
        if (v[SW-1]) begin
            c = '0;
        end else if (v > COMP_MAX) begin
            c = '1;
        end else begin
            c = v[IN_W-1:0];
        end
        return c[IN_W-1 -: OUT_W];
    endfunction

    // Global advance enable. Depends only on the output register and the
    // downstream ready, so tready never forms a path from the input side.
    logic en;
    assign en                  = !m_axis_video.tvalid || m_axis_video.tready;
    assign s_axis_video.tready = en;

    // Stage 1 state
    logic              v1;
    logic [3*IN_W-1:0] rgb1;
    mode_t             mode1;
    logic              last1;
    logic              user1;

    // Stage 2 state
    logic                 v2;
    logic signed [PW-1:0] prod2 [9];
    logic [3*IN_W-1:0]    rgb2;
    mode_t                mode2;
    logic                 last2;
    logic                 user2;

    // Stage 2 combinational inputs
    logic [IN_W-1:0]      comp1 [3];
    logic signed [PW-1:0] prod_d [9];

    always_comb begin
        comp1[0] = rgb1[3*IN_W-1 -: IN_W];
        comp1[1] = rgb1[IN_W-1:0];
        comp1[2] = rgb1[2*IN_W-1 -: IN_W];
        for (int ch = 0; ch < 3; ch++) begin
            for (int c = 0; c < 3; c++) begin
                prod_d[ch*3 + c] = mul(comp1[c], COEF[ch*3 + c]);
            end
        end
    end

    // Stage 3 combinational: sum, round, floor-shift, offset, clamp, format.
    logic signed [SW-1:0] sum_d   [3];
    logic signed [SW-1:0] shift_d [3];
    logic [OUT_W-1:0]     y_c;
    logic [OUT_W-1:0]     cb_c;
    logic [OUT_W-1:0]     cr_c;
    logic [3*OUT_W-1:0]   out_d;

    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            sum_d[ch] = SW'(prod2[ch*3]) + SW'(prod2[ch*3 + 1])
                      + SW'(prod2[ch*3 + 2]) + ROUND;
            shift_d[ch] = sum_d[ch] >>> FRAC;
        end
        y_c  = clamp_top(shift_d[0]);
        cb_c = clamp_top(shift_d[1] + CHROMA_OFS);
        cr_c = clamp_top(shift_d[2] + CHROMA_OFS);

        case (mode2)
            MODE_PASS: out_d = {rgb2[3*IN_W-1 -: OUT_W],
                                rgb2[2*IN_W-1 -: OUT_W],
                                rgb2[IN_W-1 -: OUT_W]};
            MODE_GREY: out_d = {GREY_MID, GREY_MID, y_c};
            default:   out_d = {cr_c, cb_c, y_c};
        endcase
    end

    // Whole pipeline advances in lockstep on en; bubbles ride along with a
    // cleared valid. Reset empties every stage so nothing in flight survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            rgb1  <= '0;
            mode1 <= MODE_YCBCR;
            last1 <= 1'b0;
            user1 <= 1'b0;
            v2    <= 1'b0;
            rgb2  <= '0;
            mode2 <= MODE_YCBCR;
            last2 <= 1'b0;
            user2 <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                prod2[i] <= '0;
            end
            m_axis_video.tvalid <= 1'b0;
            m_axis_video.tdata  <= '0;
            m_axis_video.tlast  <= 1'b0;
            m_axis_video.tuser  <= 1'b0;
        end else if (en) begin
            v1    <= s_axis_video.tvalid;
            rgb1  <= (mode_t'(mode) == MODE_CONST) ? sel_rgb : s_axis_video.tdata;
            mode1 <= mode_t'(mode);
            last1 <= s_axis_video.tlast;
            user1 <= s_axis_video.tuser;

            v2    <= v1;
            rgb2  <= rgb1;
            mode2 <= mode1;
            last2 <= last1;
            user2 <= user1;
            for (int i = 0; i < 9; i++) begin
                prod2[i] <= prod_d[i];
            end

            m_axis_video.tvalid <= v2;
            m_axis_video.tdata  <= out_d;
            m_axis_video.tlast  <= last2;
            m_axis_video.tuser  <= user2;
        end
    end

    // Frames are counted where they leave the block, on the accepted beat
    // carrying start-of-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (m_axis_video.tvalid && m_axis_video.tready && m_axis_video.tuser) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ycbcr_stream_conv.sv
// ---------------------------------------------------------------------------
// tb_ycbcr_stream_conv
//
// Directed bench for ycbcr_stream_conv with the default 8-bit parameters.
// Output beats are collected by a negedge monitor into a queue and compared
// against hand-computed pixels; the ramp uses a small integer model of the
// conversion. The monitor also checks the tready/backpressure relation on
// every cycle.
// ---------------------------------------------------------------------------
module tb_ycbcr_stream_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] sel_rgb = 24'h0000FF;
    logic [15:0] frame_cnt;

    logic rdy_drv    = 1'b1;
    logic rand_rdy   = 1'b0;
    logic capture_en = 1'b1;
    logic mon_en     = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [25:0] outq [$];
    logic [25:0] exp_arr [64];

    ycbcr_stream_conv_if #(.W(8)) s_if ();
    ycbcr_stream_conv_if #(.W(8)) m_if ();

    assign m_if.tready = rdy_drv;

    ycbcr_stream_conv dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .sel_rgb      (sel_rgb),
        .s_axis_video (s_if),
        .m_axis_video (m_if),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] refConv(input logic [23:0] p);
        int r, g, b, y, cb, cr;
        r  = int'(p[23:16]);
        b  = int'(p[15:8]);
        g  = int'(p[7:0]);
        y  = clamp8((77 * r + 150 * g + 29 * b + 128) >>> 8);
        cb = clamp8(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128);
        cr = clamp8(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128);
        return {8'(cr), 8'(cb), 8'(y)};
    endfunction

    // Downstream ready: always 1 unless the random stall phase is on.
    always begin
        @(posedge clk);
        #1;
        rdy_drv = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("tready_rule", 64'(s_if.tready), 64'(!(m_if.tvalid && !m_if.tready)));
            if (capture_en && m_if.tvalid && m_if.tready) begin
                outq.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
            end
        end
    end

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [23:0] d, input logic [1:0] md,
                                 input logic l, input logic u);
        int budget;
        budget       = 0;
        s_if.tdata   = d;
        mode         = md;
        s_if.tlast   = l;
        s_if.tuser   = u;
        s_if.tvalid  = 1'b1;
        @(negedge clk);
        while (!s_if.tready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!s_if.tready) checkOutput("accept_tmo", 64'(s_if.tready), 64'(1));
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    task automatic waitOutputs(input int n);
        int budget;
        budget = 0;
        while (outq.size() < n && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (outq.size() < n) checkOutput("drain_tmo", 64'(outq.size()), 64'(n));
    endtask

    task automatic popCheck(input string tag, input logic [23:0] d, input logic l, input logic u);
        logic [25:0] got;
        waitOutputs(1);
        if (outq.size() > 0) begin
            got = outq.pop_front();
            checkOutput({tag, "_data"}, 64'(got[23:0]), 64'(d));
            checkOutput({tag, "_last"}, 64'(got[24]), 64'(l));
            checkOutput({tag, "_user"}, 64'(got[25]), 64'(u));
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  r, g, b;
        logic [23:0] pix;
        logic        l, u;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tvalid", 64'(m_if.tvalid), 64'(0));
        checkOutput("rst_tdata",  64'(m_if.tdata),  64'(0));
        checkOutput("rst_tlast",  64'(m_if.tlast),  64'(0));
        checkOutput("rst_tuser",  64'(m_if.tuser),  64'(0));
        checkOutput("rst_fcnt",   64'(frame_cnt),   64'(0));
        checkOutput("rst_tready", 64'(s_if.tready), 64'(1));
        rst    = 1'b0;
        mon_en = 1'b1;

        // White, with latency: visible after the third edge counting acceptance
        applyStimulus(24'hFFFFFF, 2'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("white_lat2", 64'(m_if.tvalid), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("white_lat3", 64'(m_if.tvalid), 64'(1));
        checkOutput("white_now",  64'(m_if.tdata),  64'h8080FF);
        popCheck("white", 24'h8080FF, 1'b1, 1'b1);

        // Saturating primaries: red then blue back to back
        applyStimulus(24'hFF0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(24'h00FF00, 2'd0, 1'b0, 1'b0);
        popCheck("red",  {8'd255, 8'd85,  8'd77}, 1'b0, 1'b0);
        popCheck("blue", {8'd107, 8'd255, 8'd29}, 1'b0, 1'b0);

        // Per-beat mode switches 0 -> 1 -> 2 -> 3, sel_rgb is pure green
        sel_rgb = 24'h0000FF;
        applyStimulus(24'hFFFFFF, 2'd0, 1'b0, 1'b0);
        applyStimulus(24'h123456, 2'd1, 1'b0, 1'b0);
        applyStimulus(24'hABCDEF, 2'd2, 1'b0, 1'b1);
        applyStimulus(24'hFF0000, 2'd3, 1'b1, 1'b0);
        popCheck("m0_conv",  24'h8080FF,               1'b0, 1'b0);
        popCheck("m1_pass",  24'h123456,               1'b0, 1'b0);
        popCheck("m2_const", {8'd21, 8'd43, 8'd149},   1'b0, 1'b1);
        popCheck("m3_grey",  {8'd128, 8'd128, 8'd77},  1'b1, 1'b0);

        // 64-beat ramp under random downstream stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 64; i++) begin
            r   = 8'(i * 4);
            b   = 8'(255 - i * 3);
            g   = 8'(i * 5 + 3);
            pix = {r, b, g};
            l   = (i % 8 == 7);
            u   = (i == 0);
            exp_arr[i] = {u, l, refConv(pix)};
            applyStimulus(pix, 2'd0, l, u);
        end
        waitOutputs(64);
        for (int i = 0; i < 64; i++) begin
            popCheck($sformatf("ramp%0d", i), exp_arr[i][23:0], exp_arr[i][24], exp_arr[i][25]);
        end
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Three 4x2 frames
        pulseReset();
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 8; p++) begin
                applyStimulus({8'(f * 40), 8'(p * 20), 8'(p)}, 2'd0, (p % 4 == 3), (p == 0));
            end
        end
        waitOutputs(24);
        @(posedge clk);
        #1;
        checkOutput("frames3", 64'(frame_cnt), 64'(3));
        if (outq.size() >= 24) begin
            checkOutput("frm_user0", 64'(outq[0][25]), 64'(1));
            checkOutput("frm_user1", 64'(outq[1][25]), 64'(0));
            checkOutput("frm_last3", 64'(outq[3][24]), 64'(1));
            checkOutput("frm_user8", 64'(outq[8][25]), 64'(1));
        end
        outq.delete();

        // Reset with two beats in flight
        applyStimulus(24'hFFFFFF, 2'd0, 1'b0, 1'b1);
        applyStimulus(24'hFFFFFF, 2'd0, 1'b0, 1'b1);
        pulseReset();
        checkOutput("mid_rst_tvalid", 64'(m_if.tvalid), 64'(0));
        checkOutput("mid_rst_fcnt",   64'(frame_cnt),   64'(0));
        repeat (6) @(posedge clk);
        #1;
        checkOutput("no_stale", 64'(outq.size()), 64'(0));
        applyStimulus(24'h0000FF, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("post_rst_lat2", 64'(m_if.tvalid), 64'(0));
        @(posedge clk);
        #1;
        checkOutput("post_rst_lat3", 64'(m_if.tvalid), 64'(1));
        checkOutput("post_rst_now",  64'(m_if.tdata),  64'h152B95);
        popCheck("post_rst", 24'h152B95, 1'b0, 1'b0);

        // frame_cnt wrap: 65535 start-of-frame beats, then one more
        capture_en = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(24'h010203, 2'd0, 1'b0, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        checkOutput("fcnt_max", 64'(frame_cnt), 64'hFFFF);
        applyStimulus(24'h010203, 2'd0, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("fcnt_wrap", 64'(frame_cnt), 64'(0));
        capture_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
